// File: rtl/instruction_loader.sv
// Boot loader: receives a framed byte stream, assembles big-endian words, writes them
// to instruction RAM and releases CpuHold once the frame checksum matches.
`timescale 1ns/1ps
module instruction_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ByteData,
  input  logic        ByteValid,
  output logic        ByteReady,
  input  logic        Start,
  output logic        WriteEnable,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [2:0]  state_dbg
);

  // Byte handshake: a byte transfers on a rising edge where ByteValid && ByteReady.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t      state;
  logic [8:0]  count;
  logic [1:0]  byte_idx;
  logic [7:0]  word_idx;
  logic [7:0]  csum;
  logic [23:0] asm_word;

  logic        accept;
  logic [31:0] asm_next;
  logic [8:0]  word_next;

  assign accept    = ByteValid && ByteReady;
  assign asm_next  = {asm_word, ByteData};
  assign word_next = {1'b0, word_idx} + 9'd1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      count        <= 9'd0;
      byte_idx     <= 2'd0;
      word_idx     <= 8'd0;
      csum         <= 8'd0;
      asm_word     <= 24'd0;
      ByteReady    <= 1'b0;
      WriteEnable  <= 1'b0;
      WriteAddress <= BASE_ADDR;
      WriteData    <= 32'd0;
      CpuHold      <= 1'b1;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      WriteEnable <= 1'b0;
      case (state)
        S_IDLE: begin
          ByteReady <= 1'b1;
          if (accept && ByteData == SYNC_BYTE) state <= S_COUNT;
        end
        S_COUNT: begin
          if (accept) begin
            // A count byte of zero encodes a full 256-word image.
            count    <= (ByteData == 8'd0) ? 9'd256 : {1'b0, ByteData};
            byte_idx <= 2'd0;
            word_idx <= 8'd0;
            csum     <= 8'd0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_word <= asm_next[23:0];
            csum     <= csum ^ ByteData;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              WriteEnable  <= 1'b1;
              WriteData    <= asm_next;
              WriteAddress <= BASE_ADDR + {22'd0, word_idx, 2'b00};
              word_idx     <= word_idx + 8'd1;
              if (word_next == count) state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            ByteReady <= 1'b0;
            if (ByteData == csum) begin
              state   <= S_DONE;
              Done    <= 1'b1;
              CpuHold <= 1'b0;
            end else begin
              state <= S_ERROR;
              Error <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (Start) begin
            state     <= S_IDLE;
            Done      <= 1'b0;
            CpuHold   <= 1'b1;
            ByteReady <= 1'b1;
          end
        end
        S_ERROR: begin
          if (Start) begin
            state     <= S_IDLE;
            Error     <= 1'b0;
            ByteReady <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: frames built from word lists, expected RAM writes
// derived from frame contents and checked by a write monitor.
`timescale 1ns/1ps
module tb_instruction_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ByteData = 8'd0;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic        Start = 1'b0;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [2:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];
  logic [31:0] frame_words[$];

  instruction_loader #(.SYNC_BYTE(8'hA5), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(rst_n), .ByteData(ByteData), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .Start(Start), .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress), .WriteData(WriteData), .CpuHold(CpuHold),
    .Done(Done), .Error(Error), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard: RAM write monitor ----------------
  always @(negedge clk) begin
    if (rst_n && WriteEnable === 1'b1) begin
      logic [63:0] exp;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", WriteAddress, WriteData);
      end else begin
        exp = exp_q.pop_front();
        if ({WriteAddress, WriteData} !== exp) begin
          miscompares++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   WriteAddress, WriteData, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) @(negedge clk);
    ByteData  = b;
    ByteValid = 1'b1;
    tries = 0;
    while (ByteReady !== 1'b1 && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake: ByteReady=%b after %0d cycles, required 1", ByteReady, tries);
      ByteValid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    ByteValid = 1'b0;
  endtask

  // gap < 0 selects a random gap of 0..3 cycles before each byte.
  task automatic send_frame(input logic [7:0] cnt, input bit corrupt, input int gap);
    logic [7:0] ck;
    int g;
    ck = 8'd0;
    foreach (frame_words[i]) begin
      ck = ck ^ frame_words[i][31:24] ^ frame_words[i][23:16] ^ frame_words[i][15:8] ^ frame_words[i][7:0];
      exp_q.push_back({BASE + 32'(i * 4), frame_words[i]});
    end
    if (corrupt) ck = ck ^ 8'h01;
    g = (gap < 0) ? $urandom_range(0, 3) : gap;
    send_byte(8'hA5, g);
    g = (gap < 0) ? $urandom_range(0, 3) : gap;
    send_byte(cnt, g);
    foreach (frame_words[i]) begin
      for (int k = 3; k >= 0; k--) begin
        g = (gap < 0) ? $urandom_range(0, 3) : gap;
        send_byte(frame_words[i][k*8 +: 8], g);
      end
    end
    g = (gap < 0) ? $urandom_range(0, 3) : gap;
    send_byte(ck, g);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic check_status(input string name, input logic d, input logic e,
                              input logic h, input logic r);
    vectors++;
    if ({Done, Error, CpuHold, ByteReady} !== {d, e, h, r}) begin
      miscompares++;
      $display("FAIL %s: got Done/Error/CpuHold/ByteReady=%b%b%b%b, required %b%b%b%b",
               name, Done, Error, CpuHold, ByteReady, d, e, h, r);
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string name);
    check_status(name, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({WriteEnable, WriteAddress, WriteData} !== {1'b0, BASE, 32'd0}) begin
      miscompares++;
      $display("FAIL %s_write_port: got we=%b addr=%h data=%h, required 0 %h 0",
               name, WriteEnable, WriteAddress, WriteData, BASE);
    end
  endtask

  task automatic load_nominal();
    frame_words.delete();
    frame_words.push_back(32'h0800_0003);
    frame_words.push_back(32'h0800_0015);
    frame_words.push_back(32'h0800_0016);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_status("ready_after_reset", 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_nominal();
    load_nominal();
    send_frame(8'd3, 1'b0, 0);
    check_status("nominal_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("nominal_writes");
  endtask

  task automatic test_garbage_gaps();
    pulse_start();
    send_byte(8'h00, 3);
    send_byte(8'hFF, 3);
    send_byte(8'h5A, 3);
    frame_words.delete();
    frame_words.push_back(32'h2004_0003);
    send_frame(8'd1, 1'b0, 3);
    check_status("garbage_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("garbage_writes");
  endtask

  task automatic test_count0();
    pulse_start();
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back(32'(i));
    send_frame(8'd0, 1'b0, 0);
    check_status("count0_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("count0_writes");
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    load_nominal();
    send_frame(8'd3, 1'b1, 0);
    check_status("bad_ck_error", 1'b0, 1'b1, 1'b1, 1'b0);
    check_drained("bad_ck_writes");
    pulse_start();
    check_status("bad_ck_rearm", 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midword();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midword_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_nominal();
    send_frame(8'd3, 1'b0, 1);
    check_status("after_reset_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("after_reset_writes");
  endtask

  task automatic test_reload();
    pulse_start();
    check_status("reload_start", 1'b0, 1'b0, 1'b1, 1'b1);
    frame_words.delete();
    frame_words.push_back(32'hDEAD_BEEF);
    frame_words.push_back(32'h1234_5678);
    send_frame(8'd2, 1'b0, 0);
    check_status("reload_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("reload_writes");
    // Start is only honoured in DONE/ERROR; a second pulse after re-arming changes nothing.
    pulse_start();
    pulse_start();
    check_status("start_ignored_idle", 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int n;
      bit bad;
      n   = $urandom_range(1, 12);
      bad = ($urandom_range(0, 3) == 0);
      frame_words.delete();
      for (int i = 0; i < n; i++) frame_words.push_back($urandom);
      send_frame(8'(n), bad, -1);
      if (bad) check_status("random_error", 1'b0, 1'b1, 1'b1, 1'b0);
      else     check_status("random_done", 1'b1, 1'b0, 1'b0, 1'b0);
      check_drained("random_writes");
      pulse_start();
      check_status("random_rearm", 1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_garbage_gaps();
    test_count0();
    test_bad_checksum();
    test_reset_midword();
    test_reload();
    test_random();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the pipeline's instruction store. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and issues single-cycle word writes to the instruction RAM. The write address uses the same word indexing as the fetch path (Address[9:2]). The block holds the CPU in reset until a load frame completes with a correct checksum, then releases it.

## Interface

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be word-aligned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ByteData  input  8  incoming stream byte.
- ByteValid  input  1  ByteData is valid.
- ByteReady  output  1  loader accepts a byte this cycle. A byte transfers when ByteValid && ByteReady at the clock edge.
- Start  input  1  single-cycle pulse. Re-arms the loader from DONE or ERROR.
- WriteEnable  output  1  one-cycle instruction-RAM write strobe.
- WriteAddress  output  32  byte address of the write: BASE_ADDR + 4*index.
- WriteData  output  32  assembled instruction word.
- CpuHold  output  1  holds the pipeline in reset while high.
- Done  output  1  load completed and checksum passed (level).
- Error  output  1  checksum mismatch (level).

## Operation

Frame format: SYNC_BYTE, then a count byte N, then N words of 4 bytes each (MSB first), then a checksum byte.
- Count byte 0 means 256 words.
- Checksum is the XOR of all word bytes only. The sync and count bytes are excluded.

States:
- IDLE: accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE moves to COUNT.
- COUNT: the accepted byte is latched as the word count, with 0 mapped to 256 (9-bit counter). Clears the byte index, word index and running XOR. Moves to DATA.
- DATA: each accepted byte is shifted into a 32-bit assembly register, {asm[23:0], ByteData}, and XORed into the running checksum. The 2-bit byte counter wraps 3→0.
  - On the 4th byte: the next cycle issues the write and the word index increments.
  - When the word index reaches the count: moves to CHECK.
- CHECK: the accepted byte is compared with the running XOR. Equal → DONE; unequal → ERROR.
- DONE: ByteReady=0, Done=1, CpuHold=0. A Start pulse returns to IDLE with CpuHold=1.
- ERROR: ByteReady=0, Error=1, CpuHold=1. A Start pulse returns to IDLE.

Other rules:
- ByteReady=1 in IDLE, COUNT, DATA and CHECK. There is no back-pressure from the RAM; the write port is always ready.
- Word index is 8 bits. WriteAddress = BASE_ADDR + {22'b0, index, 2'b00}. Index 255 → 0x3FC with BASE_ADDR=0. The index never exceeds count-1.
- Start outside DONE/ERROR is ignored.
- The loader never clears RAM. Words written before an error or reset remain in RAM.

## Timing

Reset values (asynchronous on reset=0):
- State IDLE, all counters 0, running XOR 0.
- WriteEnable=0, WriteAddress=BASE_ADDR, WriteData=0.
- CpuHold=1, Done=0, Error=0, ByteReady=0.
- ByteReady=1 from the first clock edge after reset deasserts.

Write and handshake timing:
- WriteEnable, WriteAddress and WriteData are registered. They are valid together for exactly one cycle, the cycle after the edge that accepted the 4th byte of a word.
- A new byte may be accepted during the write cycle. Back-to-back bytes every cycle are sustained with no stall.
- ByteValid gaps of any length are tolerated in every state. Partial word state is held across gaps.

Completion timing:
- Done/Error and the CpuHold change become visible the cycle after the checksum byte is accepted.
- The final WriteEnable pulse precedes that cycle (N≥1 guarantees ordering).

Reset mid-frame: the partially assembled word is not written, and the next frame must begin with SYNC_BYTE.

## Test plan

- Nominal 3-word load: stream A5, 03, 08 00 00 03, 08 00 00 15, 08 00 00 16, checksum 08 -> three WriteEnable pulses with (0x0, 0x08000003), (0x4, 0x08000015), (0x8, 0x08000016); Done=1, CpuHold=0, ByteReady=0.
- Leading garbage and gaps: send 00, FF, 5A before A5, then a 1-word frame 20 04 00 03 with checksum 27, with ByteValid dropped for 3 cycles between every byte -> garbage ignored, one write (0x0, 0x20040003), Done=1.
- Count 0: A5, 00, then 256 words with word i = i (bytes 00 00 00 i), checksum 00 -> 256 writes; last write at address 0x3FC with data 0x000000FF; Done=1.
- Bad checksum: nominal frame with checksum 09 -> the three writes still occur, Error=1, Done=0, CpuHold=1, ByteReady=0. A Start pulse -> IDLE, Error=0, ByteReady=1.
- Reset mid-word: after A5, 02, 08, 00 are accepted, pulse reset low -> no WriteEnable, all outputs at reset values. A fresh nominal frame then loads correctly.
- Reload from DONE: after a successful load, pulse Start -> CpuHold=1, Done=0 next cycle. A second frame with different data overwrites from address 0.
